// File: rtl/set_scan_ctrl.sv
// -----------------------------------------------------------------------------
// set_scan_ctrl
//   Job sequencer for the three-circle coverage PE. A job is three centres,
//   three radii and a set-expression mode. The block latches the job, sweeps
//   every grid point (x,y) in 1..GRID through the PE one point per cycle
//   (X fastest), and counts the points whose covered bits satisfy the selected
//   expression. The PE is combinational: covered_i reflects coord_o and the
//   latched buffers within the same cycle.
//
//   Handshake: start_i is a level sampled on a rising edge only while idle
//   (busy_o=0); a sampled start launches the job and any start_i seen while
//   busy_o=1 is dropped, not queued. valid_o is a single-cycle strobe that
//   marks candidate_o as the result of the job that just finished;
//   candidate_o then holds until the next job completes.
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   start_i       job request
//   central_i     {A_X,A_Y,B_X,B_Y,C_X,C_Y}, MSB first
//   radius_i      {A_R,B_R,C_R}, MSB first
//   mode_i        00: a  01: a&b  10: a^b  11: exactly two of a,b,c
//   covered_i     from PE: [2]=in A, [1]=in B, [0]=in C
//   coord_o       {X,Y} to PE
//   cent_buf_o    latched centres to PE
//   r_buf_o       latched radii to PE
//   busy_o        high while scanning and in the result cycle
//   valid_o       one-cycle result strobe
//   candidate_o   point count of the last completed job
// -----------------------------------------------------------------------------
module set_scan_ctrl #(
   parameter int GRID    = 8,
   parameter int COORD_W = 4,
   parameter int CNT_W   = 7
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   input  logic [6*COORD_W-1:0]   central_i,
   input  logic [3*COORD_W-1:0]   radius_i,
   input  logic [1:0]             mode_i,
   input  logic [2:0]             covered_i,
   output logic [2*COORD_W-1:0]   coord_o,
   output logic [6*COORD_W-1:0]   cent_buf_o,
   output logic [3*COORD_W-1:0]   r_buf_o,
   output logic                   busy_o,
   output logic                   valid_o,
   output logic [CNT_W-1:0]       candidate_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [COORD_W-1:0] GRID_C = COORD_W'(GRID);
   localparam logic [COORD_W-1:0] ONE_C  = COORD_W'(1);

   state_t                 state_q, state_d;
   logic [COORD_W-1:0]     x_q, x_d;
   logic [COORD_W-1:0]     y_q, y_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [CNT_W-1:0]       cand_q, cand_d;
   logic [6*COORD_W-1:0]   cent_q, cent_d;
   logic [3*COORD_W-1:0]   rad_q, rad_d;
   logic [1:0]             mode_q, mode_d;

   logic                   match;
   logic [CNT_W-1:0]       count_inc;

   // Set expression over the PE's covered bits for the current point.
   always_comb begin
      match = 1'b0;
      case (mode_q)
         2'b00:   match = covered_i[2];
         2'b01:   match = covered_i[2] & covered_i[1];
         2'b10:   match = covered_i[2] ^ covered_i[1];
         default: match = (covered_i[2] & covered_i[1] & ~covered_i[0]) |
                          (covered_i[2] & ~covered_i[1] & covered_i[0]) |
                          (~covered_i[2] & covered_i[1] & covered_i[0]);
      endcase
   end

   assign count_inc = count_q + CNT_W'(match);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      count_d = count_q;
      cand_d  = cand_q;
      cent_d  = cent_q;
      rad_d   = rad_q;
      mode_d  = mode_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               cent_d  = central_i;
               rad_d   = radius_i;
               mode_d  = mode_i;
               count_d = '0;
               x_d     = ONE_C;
               y_d     = ONE_C;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            count_d = count_inc;
            if (x_q == GRID_C) begin
               x_d = ONE_C;
               if (y_q == GRID_C) begin
                  // Last point: the count including this point is the result.
                  y_d     = ONE_C;
                  cand_d  = count_inc;
                  state_d = S_DONE;
               end else begin
                  y_d = y_q + ONE_C;
               end
            end else begin
               x_d = x_q + ONE_C;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         x_q     <= ONE_C;
         y_q     <= ONE_C;
         count_q <= '0;
         cand_q  <= '0;
         cent_q  <= '0;
         rad_q   <= '0;
         mode_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         count_q <= count_d;
         cand_q  <= cand_d;
         cent_q  <= cent_d;
         rad_q   <= rad_d;
         mode_q  <= mode_d;
      end
   end

   assign coord_o     = {x_q, y_q};
   assign cent_buf_o  = cent_q;
   assign r_buf_o     = rad_q;
   assign busy_o      = (state_q != S_IDLE);
   assign valid_o     = (state_q == S_DONE);
   assign candidate_o = cand_q;

endmodule

// File: tb/tb_set_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_set_scan_ctrl
//   Directed bench for set_scan_ctrl at GRID=8. covered_i comes from a stub
//   PE driven by coord_o; expected counts are worked out by hand from the stub
//   regions.
// -----------------------------------------------------------------------------
module tb_set_scan_ctrl;

   localparam int GRID    = 8;
   localparam int COORD_W = 4;
   localparam int CNT_W   = 7;

   localparam logic [23:0] CENT_A = 24'h123456;
   localparam logic [11:0] RAD_A  = 12'h789;
   localparam logic [23:0] CENT_B = 24'hA5C3E1;
   localparam logic [11:0] RAD_B  = 12'h2D4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start_i;
   logic [23:0]          central_i;
   logic [11:0]          radius_i;
   logic [1:0]           mode_i;
   logic [2:0]           covered_i;
   logic [7:0]           coord_o;
   logic [23:0]          cent_buf_o;
   logic [11:0]          r_buf_o;
   logic                 busy_o;
   logic                 valid_o;
   logic [CNT_W-1:0]     candidate_o;

   int tests_run    = 0;
   int tests_failed = 0;

   // Stub PE: 0 = inside all three circles; 1 = a=(X<=4), b=(Y<=4), c=0;
   // 2 = same a,b with c=1.
   int stub_mode = 0;

   // Results of the most recent run_to_done.
   logic [7:0]  coord_log [64];
   int          busy_cycles;
   int          valid_cycle;
   int          valid_count;
   int          hold_err;
   logic [23:0] mid_cent;
   logic [11:0] mid_rad;

   set_scan_ctrl #(
      .GRID    (GRID),
      .COORD_W (COORD_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .central_i   (central_i),
      .radius_i    (radius_i),
      .mode_i      (mode_i),
      .covered_i   (covered_i),
      .coord_o     (coord_o),
      .cent_buf_o  (cent_buf_o),
      .r_buf_o     (r_buf_o),
      .busy_o      (busy_o),
      .valid_o     (valid_o),
      .candidate_o (candidate_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   always_comb begin
      covered_i = 3'b000;
      case (stub_mode)
         0:       covered_i = 3'b111;
         1:       covered_i = {coord_o[7:4] <= 4'd4, coord_o[3:0] <= 4'd4, 1'b0};
         default: covered_i = {coord_o[7:4] <= 4'd4, coord_o[3:0] <= 4'd4, 1'b1};
      endcase
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, run incomplete");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   // Called at a falling edge; start is sampled on the next rising edge (E0).
   // Returns at the falling edge of cycle 1 after E0.
   task automatic start_job(input logic [1:0] m, input logic [23:0] c,
                            input logic [11:0] r);
      start_i   = 1'b1;
      mode_i    = m;
      central_i = c;
      radius_i  = r;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   // Observes cycles 1.. after E0 at each falling edge until the block is idle
   // again (bounded). Optionally pulses start at two cycles, toggles the job
   // inputs, and checks candidate_o holds hold_val before the result cycle.
   task automatic run_to_done(input int pulse_a, input int pulse_b,
                              input bit toggle, input bit hold_chk,
                              input logic [CNT_W-1:0] hold_val);
      busy_cycles = 0;
      valid_cycle = -1;
      valid_count = 0;
      hold_err    = 0;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         start_i = 1'b0;
         if (busy_o) busy_cycles++;
         if (valid_o) begin
            valid_count++;
            if (valid_cycle < 0) valid_cycle = cyc;
         end
         if (cyc <= 64) coord_log[cyc-1] = coord_o;
         if (cyc == 30) begin
            mid_cent = cent_buf_o;
            mid_rad  = r_buf_o;
         end
         if (hold_chk && cyc < 65 && candidate_o !== hold_val) hold_err++;
         if (cyc > 1 && !busy_o) break;
         if (cyc == pulse_a || cyc == pulse_b) start_i = 1'b1;
         if (toggle) begin
            central_i = 24'($urandom);
            radius_i  = 12'($urandom);
            mode_i    = 2'($urandom);
         end
         @(negedge clk);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      tests_run++;
      if (coord_o !== 8'h11) begin
         tests_failed++;
         $display("FAIL reset_coord: got %h expected 11", coord_o);
      end
      tests_run++;
      if ({busy_o, valid_o} !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_busy_valid: got %b expected 00", {busy_o, valid_o});
      end
      tests_run++;
      if ({cent_buf_o, r_buf_o, candidate_o} !== '0) begin
         tests_failed++;
         $display("FAIL reset_buffers: cent=%h r=%h cand=%0d expected zeros",
                  cent_buf_o, r_buf_o, candidate_o);
      end
   endtask

   task automatic test_mode01();
      stub_mode = 0;
      start_job(2'b01, CENT_A, RAD_A);
      run_to_done(0, 0, 1'b0, 1'b0, '0);
      tests_run++;
      if (candidate_o !== 7'd64) begin
         tests_failed++;
         $display("FAIL mode01_count: got %0d expected 64", candidate_o);
      end
      tests_run++;
      if (valid_cycle !== 65 || valid_count !== 1) begin
         tests_failed++;
         $display("FAIL mode01_valid: cycle %0d count %0d expected cycle 65 count 1",
                  valid_cycle, valid_count);
      end
      tests_run++;
      if (busy_cycles !== 65) begin
         tests_failed++;
         $display("FAIL mode01_busy: got %0d cycles expected 65", busy_cycles);
      end
   endtask

   task automatic test_reset_mid();
      stub_mode = 0;
      start_job(2'b01, CENT_B, RAD_B);
      repeat (19) @(negedge clk);
      // Cycle 20 after the start edge scans point 20: (4,3).
      tests_run++;
      if (coord_o !== 8'h43 || busy_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL midreset_pre: coord %h busy %b expected 43 1", coord_o, busy_o);
      end
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if ({busy_o, valid_o} !== 2'b00 || coord_o !== 8'h11) begin
         tests_failed++;
         $display("FAIL midreset_state: busy %b valid %b coord %h expected 0 0 11",
                  busy_o, valid_o, coord_o);
      end
      tests_run++;
      if ({cent_buf_o, r_buf_o, candidate_o} !== '0) begin
         tests_failed++;
         $display("FAIL midreset_buffers: cent=%h r=%h cand=%0d expected zeros",
                  cent_buf_o, r_buf_o, candidate_o);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({busy_o, valid_o} !== 2'b00) begin
         tests_failed++;
         $display("FAIL midreset_after: busy %b valid %b expected 0 0", busy_o, valid_o);
      end
   endtask

   task automatic test_mode10_sweep();
      int sweep_err;
      stub_mode = 1;
      start_job(2'b10, CENT_B, RAD_B);
      run_to_done(0, 0, 1'b1, 1'b0, '0);
      tests_run++;
      if (candidate_o !== 7'd32) begin
         tests_failed++;
         $display("FAIL mode10_count: got %0d expected 32", candidate_o);
      end
      tests_run++;
      if (busy_cycles !== 65 || valid_cycle !== 65 || valid_count !== 1) begin
         tests_failed++;
         $display("FAIL mode10_timing: busy %0d valid cycle %0d count %0d expected 65 65 1",
                  busy_cycles, valid_cycle, valid_count);
      end
      sweep_err = 0;
      for (int i = 0; i < 64; i++) begin
         logic [3:0] ex;
         logic [3:0] ey;
         ex = 4'((i % 8) + 1);
         ey = 4'((i / 8) + 1);
         if (coord_log[i] !== {ex, ey}) sweep_err++;
      end
      tests_run++;
      if (sweep_err !== 0) begin
         tests_failed++;
         $display("FAIL sweep_order: %0d of 64 points wrong, first=%h last=%h expected 11 88",
                  sweep_err, coord_log[0], coord_log[63]);
      end
      tests_run++;
      if (mid_cent !== CENT_B || mid_rad !== RAD_B) begin
         tests_failed++;
         $display("FAIL buffers_midjob: cent=%h r=%h expected %h %h",
                  mid_cent, mid_rad, CENT_B, RAD_B);
      end
      tests_run++;
      if (cent_buf_o !== CENT_B || r_buf_o !== RAD_B) begin
         tests_failed++;
         $display("FAIL buffers_hold: cent=%h r=%h expected %h %h",
                  cent_buf_o, r_buf_o, CENT_B, RAD_B);
      end
   endtask

   task automatic test_mode11();
      stub_mode = 1;
      start_job(2'b11, CENT_A, RAD_A);
      run_to_done(0, 0, 1'b0, 1'b0, '0);
      tests_run++;
      if (candidate_o !== 7'd16) begin
         tests_failed++;
         $display("FAIL mode11_c0: got %0d expected 16", candidate_o);
      end
      stub_mode = 2;
      start_job(2'b11, CENT_A, RAD_A);
      run_to_done(0, 0, 1'b0, 1'b0, '0);
      tests_run++;
      if (candidate_o !== 7'd32) begin
         tests_failed++;
         $display("FAIL mode11_c1: got %0d expected 32", candidate_o);
      end
   endtask

   task automatic test_ignored_start();
      stub_mode = 0;
      start_job(2'b01, CENT_A, RAD_A);
      // Extra starts during SCAN (cycle 10) and in the DONE cycle (65).
      run_to_done(10, 65, 1'b0, 1'b0, '0);
      tests_run++;
      if (busy_cycles !== 65 || valid_count !== 1 || candidate_o !== 7'd64) begin
         tests_failed++;
         $display("FAIL ignored_start_job: busy %0d valids %0d cand %0d expected 65 1 64",
                  busy_cycles, valid_count, candidate_o);
      end
      repeat (3) @(negedge clk);
      tests_run++;
      if (busy_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL ignored_start_idle: busy %b expected 0", busy_o);
      end
   endtask

   task automatic test_back_to_back();
      stub_mode = 1;
      start_job(2'b00, CENT_A, RAD_A);
      run_to_done(0, 0, 1'b0, 1'b0, '0);
      tests_run++;
      if (candidate_o !== 7'd32 || valid_cycle !== 65) begin
         tests_failed++;
         $display("FAIL b2b_first: cand %0d valid cycle %0d expected 32 65",
                  candidate_o, valid_cycle);
      end
      // First idle cycle, one cycle after the strobe.
      stub_mode = 0;
      start_job(2'b01, CENT_B, RAD_B);
      run_to_done(0, 0, 1'b0, 1'b1, 7'd32);
      tests_run++;
      if (hold_err !== 0) begin
         tests_failed++;
         $display("FAIL b2b_hold: candidate left 32 in %0d cycles expected 0", hold_err);
      end
      tests_run++;
      if (candidate_o !== 7'd64 || valid_cycle !== 65 || valid_count !== 1) begin
         tests_failed++;
         $display("FAIL b2b_second: cand %0d valid cycle %0d count %0d expected 64 65 1",
                  candidate_o, valid_cycle, valid_count);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst       = 1'b1;
      start_i   = 1'b0;
      central_i = '0;
      radius_i  = '0;
      mode_i    = 2'b00;
      @(negedge clk);
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_mode01();
      test_reset_mid();
      test_mode10_sweep();
      test_mode11();
      test_ignored_start();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
